sflash_sched: RTL and testbench
===============================

Name: sflash_sched

Overview:
- Transaction scheduler in front of the sflash byte engine; shares the engine between two requesters.
- Requester F: hardware fetch port. Block runs a complete quad-output read on its own: cmd, 24-bit addr, dummy, N data bytes, CS release.
- Requester C: CPU raw byte channel. CPU locks the engine and pushes bytes with its own formats.
- Arbitration happens only at transaction boundaries; nothing is ever preempted.

Parameters:
- RD_CMD, 8'h6B, read opcode sent at start of a fetch.
- FMT_SPI, 3'd2, single-lane byte, CS held low.
- FMT_QIN, 3'd6, quad-input byte, CS held low.
- FMT_END, 3'd0, terminating op: CS released, data discarded.

Ports:
- clk  in  1  system clock
- arst  in  1  async reset, active-high
- f_req  in  1  fetch request, level; held until f_ack
- f_addr  in  24  fetch byte address, sampled at f_ack
- f_len  in  8  byte count minus 1, sampled at f_ack
- f_ack  out  1  1-cycle pulse: request accepted
- f_data  out  8  fetched byte
- f_valid  out  1  1-cycle pulse: f_data valid
- f_done  out  1  1-cycle pulse: fetch complete, CS released
- c_lock  in  1  CPU requests and holds ownership
- c_gnt  out  1  CPU owns engine
- c_wr  in  1  CPU byte strobe
- c_din  in  8  CPU byte
- c_fmt  in  3  CPU byte format
- c_ready  out  1  CPU may strobe
- c_dout  out  8  last received byte (engine passthrough)
- e_ready  in  1  engine ready
- e_wr  out  1  engine byte strobe
- e_who  out  1  0 = fetch, 1 = CPU
- e_din  out  8  engine byte
- e_format  out  3  engine format
- e_dout  in  8  engine received byte

Behaviour:
- Reset values:
  - All outputs 0, except e_format = FMT_END.
  - State IDLE, pend = 0, last = 1 (CPU was last served).
  - Reset mid-transaction aborts immediately. The engine shares arst, so CS release comes from its own reset.
- Byte issue (all states):
  - Issue only when e_ready = 1 and pend = 0. e_wr = 1 for exactly one cycle, with e_din/e_format valid that cycle.
  - pend is set at issue and blanks e_ready for 2 cycles.
  - pend clears on the first e_ready = 1 after blanking. That cycle is "byte done", and e_dout is valid.
- States:
  - IDLE: choose a grant.
    - f_req only: fetch.
    - c_lock only: CPU.
    - Both: the side with last != side wins.
    - A fetch grant pulses f_ack, latches addr/len and sets last = 0 -> F_CMD.
    - A CPU grant sets c_gnt = 1, last = 1 -> C_OWN. Grant decision takes 1 cycle.
  - F_CMD, F_A2, F_A1, F_A0, F_DUMMY: send RD_CMD, addr[23:16], addr[15:8], addr[7:0], 8'h00, all with FMT_SPI. Advance on byte done.
  - F_DATA:
    - Send 8'h00 with FMT_QIN.
    - On each byte done: f_data = e_dout, f_valid pulse, decrement count.
    - After byte with count = 0 -> F_END.
    - Exactly f_len+1 pulses; f_len = 0 gives 1 byte, 255 gives 256.
  - F_END: send FMT_END byte. On byte done pulse f_done -> IDLE. f_req may already be high again; it is arbitrated next cycle.
  - C_OWN:
    - e_who = 1; c_ready = e_ready & ~pend.
    - c_wr with c_ready = 1 issues c_din/c_fmt. c_wr with c_ready = 0 is ignored.
    - c_dout = e_dout always.
    - When c_lock = 0, pend = 0 and e_ready = 1: c_gnt drops -> IDLE.
    - The CPU must end its own transaction with an FMT_END byte. The block does not insert one.
- During fetch: e_who = 0. c_gnt = 0 and c_ready = 0, and c_wr is ignored.
- f_ack, f_valid, f_done, e_wr are never high in the same cycle as a state change into IDLE from reset.

Test Plan:
- Fetch only, f_addr = 24'h123456, f_len = 1, engine model returns A5, 5A on data bytes.
  - e_din sequence 6B, 12, 34, 56, 00 (fmt 2), then 00, 00 (fmt 6), then FMT_END byte.
  - f_valid twice with A5 then 5A, then one f_done; f_ack exactly once.
- CPU only: c_lock = 1, write 9F (fmt 2), 00 (fmt 2), 00 (fmt 0), drop c_lock.
  - e_who = 1 on all three strobes; c_ready low while pend is set.
  - c_gnt falls after the last byte done; a c_wr while c_ready = 0 produces no e_wr.
- Contention after reset: f_req and c_lock both asserted.
  - Fetch served first, then CPU.
  - Re-assert both at IDLE: fetch served first again, since last = CPU after the CPU grant.
  - A fetch-then-CPU pair alternates.
- Boundaries: f_len = 0 gives exactly 1 f_valid; f_len = 255 gives 256 f_valid; e_din addresses are correct for f_addr = 24'hFFFFFF.
- Reset: assert arst during F_DATA (3rd byte).
  - All outputs return to reset values asynchronously; no f_done.
  - After release, a new f_req restarts from F_CMD.
- Back-to-back: f_req held high through f_done; second f_ack arrives the cycle after IDLE is re-entered, with no CPU starvation when c_lock is present.

Source files
------------

// File: rtl/sflash_sched.sv
// Transaction scheduler in front of the sflash byte engine: shares the engine between
// a hardware quad-read fetch port and a CPU raw byte channel, arbitrating only between transactions.
module sflash_sched #(
  parameter logic [7:0] RD_CMD  = 8'h6B,
  parameter logic [2:0] FMT_SPI = 3'd2,
  parameter logic [2:0] FMT_QIN = 3'd6,
  parameter logic [2:0] FMT_END = 3'd0
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        f_req,
  input  logic [23:0] f_addr,
  input  logic [7:0]  f_len,
  output logic        f_ack,
  output logic [7:0]  f_data,
  output logic        f_valid,
  output logic        f_done,
  input  logic        c_lock,
  output logic        c_gnt,
  input  logic        c_wr,
  input  logic [7:0]  c_din,
  input  logic [2:0]  c_fmt,
  output logic        c_ready,
  output logic [7:0]  c_dout,
  input  logic        e_ready,
  output logic        e_wr,
  output logic        e_who,
  output logic [7:0]  e_din,
  output logic [2:0]  e_format,
  input  logic [7:0]  e_dout
);

  typedef enum logic [3:0] {
    IDLE,
    F_CMD,
    F_A2,
    F_A1,
    F_A0,
    F_DUMMY,
    F_DATA,
    F_END,
    C_OWN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        pend;
  logic [1:0]  blank;
  logic        last;
  logic [23:0] addr;
  logic [7:0]  cnt;
  logic        can_issue;
  logic        byte_done;
  logic        grant_f;
  logic        grant_c;

  // e_ready is not trusted for two cycles after a strobe, so the engine has time to drop it.
  assign can_issue = e_ready & ~pend;
  assign byte_done = pend & (blank == 2'd0) & e_ready;
  assign c_dout    = e_dout;

  always_comb begin
    state_nx = state;
    grant_f  = 1'b0;
    grant_c  = 1'b0;
    e_wr     = 1'b0;
    e_who    = 1'b0;
    e_din    = 8'h00;
    e_format = FMT_END;
    c_ready  = 1'b0;
    case (state)
      IDLE: begin
        // On contention the side that was not served last wins.
        if (f_req && (!c_lock || last)) begin
          grant_f  = 1'b1;
          state_nx = F_CMD;
        end else if (c_lock) begin
          grant_c  = 1'b1;
          state_nx = C_OWN;
        end
      end
      F_CMD: begin
        e_din    = RD_CMD;
        e_format = FMT_SPI;
        e_wr     = can_issue;
        if (byte_done) state_nx = F_A2;
      end
      F_A2: begin
        e_din    = addr[23:16];
        e_format = FMT_SPI;
        e_wr     = can_issue;
        if (byte_done) state_nx = F_A1;
      end
      F_A1: begin
        e_din    = addr[15:8];
        e_format = FMT_SPI;
        e_wr     = can_issue;
        if (byte_done) state_nx = F_A0;
      end
      F_A0: begin
        e_din    = addr[7:0];
        e_format = FMT_SPI;
        e_wr     = can_issue;
        if (byte_done) state_nx = F_DUMMY;
      end
      F_DUMMY: begin
        e_format = FMT_SPI;
        e_wr     = can_issue;
        if (byte_done) state_nx = F_DATA;
      end
      F_DATA: begin
        e_format = FMT_QIN;
        e_wr     = can_issue;
        if (byte_done && cnt == 8'd0) state_nx = F_END;
      end
      F_END: begin
        e_format = FMT_END;
        e_wr     = can_issue;
        if (byte_done) state_nx = IDLE;
      end
      C_OWN: begin
        e_who    = 1'b1;
        e_din    = c_din;
        e_format = c_fmt;
        c_ready  = can_issue;
        e_wr     = c_wr & can_issue;
        // A strobe in the same cycle as the unlock is still honoured before releasing.
        if (!c_lock && can_issue && !c_wr) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      pend    <= 1'b0;
      blank   <= 2'd0;
      last    <= 1'b1;
      addr    <= 24'h000000;
      cnt     <= 8'h00;
      f_ack   <= 1'b0;
      f_valid <= 1'b0;
      f_done  <= 1'b0;
      f_data  <= 8'h00;
      c_gnt   <= 1'b0;
    end else begin
      state   <= state_nx;
      f_ack   <= grant_f;
      f_valid <= 1'b0;
      f_done  <= 1'b0;

      if (e_wr) begin
        pend  <= 1'b1;
        blank <= 2'd2;
      end else if (pend) begin
        if (blank != 2'd0) blank <= blank - 2'd1;
        else if (e_ready)  pend  <= 1'b0;
      end

      if (grant_f) begin
        addr <= f_addr;
        cnt  <= f_len;
        last <= 1'b0;
      end
      if (grant_c) begin
        last  <= 1'b1;
        c_gnt <= 1'b1;
      end
      if (state == C_OWN && state_nx == IDLE) c_gnt <= 1'b0;

      if (state == F_DATA && byte_done) begin
        f_valid <= 1'b1;
        f_data  <= e_dout;
        if (cnt != 8'd0) cnt <= cnt - 8'd1;
      end
      if (state == F_END && byte_done) f_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sflash_sched.sv
// Directed bench for sflash_sched with a small byte-engine model and a strobe log.
module tb_sflash_sched;

  localparam logic [2:0] FMT_SPI = 3'd2;
  localparam logic [2:0] FMT_QIN = 3'd6;
  localparam logic [2:0] FMT_END = 3'd0;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        f_req = 1'b0;
  logic [23:0] f_addr = 24'h0;
  logic [7:0]  f_len = 8'h0;
  logic        f_ack;
  logic [7:0]  f_data;
  logic        f_valid;
  logic        f_done;
  logic        c_lock = 1'b0;
  logic        c_gnt;
  logic        c_wr = 1'b0;
  logic [7:0]  c_din = 8'h0;
  logic [2:0]  c_fmt = 3'd0;
  logic        c_ready;
  logic [7:0]  c_dout;
  logic        e_ready;
  logic        e_wr;
  logic        e_who;
  logic [7:0]  e_din;
  logic [2:0]  e_format;
  logic [7:0]  e_dout;

  int cmp_n = 0;
  int err_n = 0;

  sflash_sched dut (
    .clk(clk), .arst(arst),
    .f_req(f_req), .f_addr(f_addr), .f_len(f_len), .f_ack(f_ack),
    .f_data(f_data), .f_valid(f_valid), .f_done(f_done),
    .c_lock(c_lock), .c_gnt(c_gnt), .c_wr(c_wr), .c_din(c_din), .c_fmt(c_fmt),
    .c_ready(c_ready), .c_dout(c_dout),
    .e_ready(e_ready), .e_wr(e_wr), .e_who(e_who), .e_din(e_din),
    .e_format(e_format), .e_dout(e_dout)
  );

  always #5 clk = ~clk;

  // Data returned for the k-th quad-input byte since time zero.
  function automatic logic [7:0] qv(input int k);
    logic [31:0] t;
    if (k == 0) return 8'hA5;
    if (k == 1) return 8'h5A;
    t = 32'(k) * 32'd37 + 32'd11;
    return t[7:0];
  endfunction

  // Engine model: busy for three cycles after each strobe, then ready with a response.
  int         qin_cnt = 0;
  int         busy;
  logic [7:0] rsp_hold;
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      e_ready  <= 1'b1;
      e_dout   <= 8'h00;
      busy     <= 0;
      rsp_hold <= 8'h00;
    end else if (e_wr) begin
      e_ready  <= 1'b0;
      busy     <= 3;
      rsp_hold <= (e_format == FMT_QIN) ? qv(qin_cnt) : ~e_din;
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        e_ready <= 1'b1;
        e_dout  <= rsp_hold;
      end
    end
  end

  logic [7:0] wr_din [0:2047];
  logic [2:0] wr_fmt [0:2047];
  logic       wr_who [0:2047];
  logic [7:0] fv_dat [0:2047];
  int wr_n = 0;
  int fv_n = 0;
  int ack_n = 0;
  int done_n = 0;
  always @(posedge clk) begin
    if (e_wr) begin
      wr_din[wr_n] <= e_din;
      wr_fmt[wr_n] <= e_format;
      wr_who[wr_n] <= e_who;
      wr_n <= wr_n + 1;
      if (e_format == FMT_QIN) qin_cnt <= qin_cnt + 1;
    end
    if (f_valid) begin
      fv_dat[fv_n] <= f_data;
      fv_n <= fv_n + 1;
    end
    if (f_ack)  ack_n  <= ack_n + 1;
    if (f_done) done_n <= done_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sig(input string tag, input int which, input logic val, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (which)
        0: ok = (f_ack === val);
        1: ok = (f_done === val);
        2: ok = (c_gnt === val);
        default: ok = (c_ready === val);
      endcase
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [23:0] a, input logic [7:0] l);
    int w0 = wr_n;
    int v0 = fv_n;
    int a0 = ack_n;
    int d0 = done_n;
    int q0 = qin_cnt;
    logic [7:0] hdr [0:4];
    hdr[0] = 8'h6B; hdr[1] = a[23:16]; hdr[2] = a[15:8]; hdr[3] = a[7:0]; hdr[4] = 8'h00;
    f_addr = a;
    f_len  = l;
    f_req  = 1'b1;
    wait_sig("fetch_ack", 0, 1'b1, 20);
    f_req = 1'b0;
    wait_sig("fetch_done", 1, 1'b1, 5000);
    @(negedge clk);
    chk("ack_count", 32'(ack_n - a0), 32'd1);
    chk("done_count", 32'(done_n - d0), 32'd1);
    chk("wr_count", 32'(wr_n - w0), 32'(l) + 32'd7);
    for (int i = 0; i < 5; i++)
      chk("hdr_op", {20'h0, wr_who[w0+i], wr_fmt[w0+i], wr_din[w0+i]}, {20'h0, 1'b0, FMT_SPI, hdr[i]});
    for (int i = 0; i <= int'(l); i++)
      chk("data_op", {20'h0, wr_who[w0+5+i], wr_fmt[w0+5+i], wr_din[w0+5+i]}, {20'h0, 1'b0, FMT_QIN, 8'h00});
    chk("end_op", {28'h0, wr_who[w0+int'(l)+6], wr_fmt[w0+int'(l)+6]}, {28'h0, 1'b0, FMT_END});
    chk("valid_count", 32'(fv_n - v0), 32'(l) + 32'd1);
    for (int i = 0; i <= int'(l); i++)
      chk("f_data", 32'(fv_dat[v0+i]), 32'(qv(q0 + i)));
  endtask

  task automatic cpu_write(input logic [7:0] d, input logic [2:0] f);
    wait_sig("c_ready_up", 3, 1'b1, 20);
    c_din = d;
    c_fmt = f;
    c_wr  = 1'b1;
    @(negedge clk);
    c_wr = 1'b0;
    chk("c_ready_pend", 32'(c_ready), 32'd0);
  endtask

  task automatic cpu_release();
    cpu_write(8'h00, FMT_END);
    c_lock = 1'b0;
    wait_sig("c_gnt_drop", 2, 1'b0, 20);
  endtask

  initial begin
    int w0;
    int v0;
    int d0;
    int a0;

    // Reset values while arst is held
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctrl", 32'({f_ack, f_valid, f_done, c_gnt, c_ready, e_wr, e_who}), 32'd0);
    chk("rst_fmt", 32'(e_format), 32'(FMT_END));
    chk("rst_data", {8'h0, f_data, e_din, c_dout}, 32'd0);
    arst = 1'b0;
    @(negedge clk);

    // Plain fetch: 6B 12 34 56 00, two quad bytes returning A5 5A, then END
    do_fetch(24'h123456, 8'd1);

    // CPU only
    c_lock = 1'b1;
    wait_sig("cpu_gnt", 2, 1'b1, 10);
    chk("cpu_who", 32'(e_who), 32'd1);
    w0 = wr_n;
    cpu_write(8'h9F, FMT_SPI);
    c_din = 8'h77;
    c_wr  = 1'b1;
    #1;
    chk("stray_wr", 32'(e_wr), 32'd0);
    @(negedge clk);
    c_wr = 1'b0;
    wait_sig("c_ready_back", 3, 1'b1, 20);
    chk("c_dout", 32'(c_dout), 32'h60);
    cpu_write(8'h00, FMT_SPI);
    cpu_write(8'h00, FMT_END);
    c_lock = 1'b0;
    @(negedge clk);
    chk("gnt_hold_pend", 32'(c_gnt), 32'd1);
    wait_sig("cpu_gnt_drop", 2, 1'b0, 20);
    chk("cpu_wr_count", 32'(wr_n - w0), 32'd3);
    chk("cpu_op0", {20'h0, wr_who[w0], wr_fmt[w0], wr_din[w0]}, {20'h0, 1'b1, FMT_SPI, 8'h9F});
    chk("cpu_op1", {20'h0, wr_who[w0+1], wr_fmt[w0+1], wr_din[w0+1]}, {20'h0, 1'b1, FMT_SPI, 8'h00});
    chk("cpu_op2", {20'h0, wr_who[w0+2], wr_fmt[w0+2], wr_din[w0+2]}, {20'h0, 1'b1, FMT_END, 8'h00});

    // Contention right after reset: fetch first, then CPU
    do_reset();
    f_len = 8'd0;
    f_req = 1'b1;
    c_lock = 1'b1;
    @(negedge clk);
    chk("cont_first", 32'({f_ack, c_gnt}), 32'b10);
    f_req = 1'b0;
    wait_sig("cont_done", 1, 1'b1, 200);
    a0 = ack_n;
    wait_sig("cont_cpu", 2, 1'b1, 10);
    cpu_write(8'h00, FMT_END);
    c_lock = 1'b0;
    wait_sig("cont_cpu_drop", 2, 1'b0, 20);
    chk("cont_no_ack", 32'(ack_n - a0), 32'd0);
    // Both again at IDLE: CPU was last, so fetch wins, then CPU
    f_req = 1'b1;
    c_lock = 1'b1;
    @(negedge clk);
    chk("rearb_first", 32'({f_ack, c_gnt}), 32'b10);
    f_req = 1'b0;
    wait_sig("rearb_done", 1, 1'b1, 200);
    @(negedge clk);
    chk("alt_cpu", 32'({f_ack, c_gnt}), 32'b01);
    cpu_release();

    // Back-to-back: f_req held through f_done, then CPU present at the next boundary
    f_req = 1'b1;
    wait_sig("b2b_ack1", 0, 1'b1, 20);
    wait_sig("b2b_done1", 1, 1'b1, 200);
    @(negedge clk);
    chk("b2b_ack2", 32'(f_ack), 32'd1);
    c_lock = 1'b1;
    wait_sig("b2b_done2", 1, 1'b1, 200);
    @(negedge clk);
    chk("no_starve", 32'({f_ack, c_gnt}), 32'b01);
    f_req = 1'b0;
    cpu_release();

    // Boundaries
    do_fetch(24'h000100, 8'd0);
    do_fetch(24'hFFFFFF, 8'd255);

    // Reset during the third data byte
    v0 = fv_n;
    d0 = done_n;
    f_addr = 24'h0A0B0C;
    f_len  = 8'd7;
    f_req  = 1'b1;
    wait_sig("mid_ack", 0, 1'b1, 20);
    f_req = 1'b0;
    for (int i = 0; i < 200 && (fv_n - v0) < 2; i++) @(negedge clk);
    chk("mid_two_valid", 32'(fv_n - v0), 32'd2);
    #2;
    arst = 1'b1;
    #1;
    chk("arst_ctrl", 32'({f_ack, f_valid, f_done, c_gnt, c_ready, e_wr, e_who}), 32'd0);
    chk("arst_fmt", 32'(e_format), 32'(FMT_END));
    chk("arst_data", {8'h0, f_data, e_din, c_dout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("arst_no_done", 32'(done_n - d0), 32'd0);
    chk("arst_no_more", 32'(fv_n - v0), 32'd2);
    do_fetch(24'hABCDEF, 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", cmp_n);
    $fatal(1);
  end

endmodule
